// File: rtl/aes_key_schedule_gen.sv
// ---------------------------------------------------------------------------
// aes_key_schedule_gen
//   AES key expansion engine for 128/192/256-bit keys. One expanded word is
//   produced per clock using a single 4-byte S-box bank. The full schedule
//   (up to 60 words) is kept in a word table that can be read by round-key
//   index at any time.
//
// Ports
//   clk            system clock, rising edge
//   reset_n        asynchronous active-low reset
//   start_in       expansion request (accepted only in IDLE)
//   key_len_in     00=128, 01=192, 10=256, 11=invalid
//   key_in         cipher key, w[0] in bits [255:224], left-aligned
//   rk_idx_in      round-key index 0..14
//   rk_out         {w[4r], w[4r+1], w[4r+2], w[4r+3]}, 0 when index > Nr
//   busy_out       high in LOAD/EXPAND/DONE
//   done_out       one-cycle pulse at completion
//   keys_valid_out table holds a complete schedule
//   err_out        one-cycle pulse when a start carried an invalid key_len
// ---------------------------------------------------------------------------
module aes_key_schedule_gen #(
   parameter int RD_REG      = 0,
   parameter int SUPPORT_256 = 1
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         start_in,
   input  logic [1:0]   key_len_in,
   input  logic [255:0] key_in,
   input  logic [3:0]   rk_idx_in,
   output logic [127:0] rk_out,
   output logic         busy_out,
   output logic         done_out,
   output logic         keys_valid_out,
   output logic         err_out
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_t;

   state_t       r_state, w_next;
   logic [1:0]   r_klen;
   logic [255:0] r_key;
   logic [5:0]   r_i;
   logic [2:0]   r_pos;      // i mod Nk, tracked incrementally
   logic [3:0]   r_rci;      // i / Nk, tracked incrementally
   logic         r_kv;
   logic         r_err;
   logic [31:0]  r_w [0:59];

   logic         w_len_ok, w_accept, w_reject, w_last;
   logic [3:0]   w_nk, w_nr;
   logic [5:0]   w_nw, w_ix_m1, w_ix_mnk;
   logic [2:0]   w_pos_last;
   logic [31:0]  w_im1, w_imnk, w_rot, w_sb_in, w_sb_out, w_t, w_new;
   logic [7:0]   w_rcon;
   logic [5:0]   w_rbase;
   logic [127:0] w_rk;

   // ---------------- key length decode ----------------
   assign w_len_ok = (key_len_in != 2'b11) && ((SUPPORT_256 != 0) || (key_len_in != 2'b10));
   assign w_accept = (r_state == S_IDLE) && start_in && w_len_ok;
   assign w_reject = (r_state == S_IDLE) && start_in && !w_len_ok;

   always_comb begin
      w_nk = 4'd8;
      w_nr = 4'd14;
      case (r_klen)
         2'b00:   begin w_nk = 4'd4; w_nr = 4'd10; end
         2'b01:   begin w_nk = 4'd6; w_nr = 4'd12; end
         default: begin w_nk = 4'd8; w_nr = 4'd14; end
      endcase
   end

   assign w_nw       = {w_nr, 2'b00} + 6'd4;
   assign w_last     = (r_i == (w_nw - 6'd1));
   assign w_pos_last = 3'(w_nk - 4'd1);

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_next = S_LOAD;
         S_LOAD:   w_next = S_EXPAND;
         S_EXPAND: if (w_last) w_next = S_DONE;
         S_DONE:   w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy_out = (r_state != S_IDLE);
      done_out = (r_state == S_DONE);
   end

   assign keys_valid_out = r_kv;
   assign err_out        = r_err;

   // ---------------- control registers ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_klen <= 2'b00;
         r_key  <= '0;
         r_i    <= '0;
         r_pos  <= '0;
         r_rci  <= '0;
         r_kv   <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_err <= w_reject;
         if (w_accept) begin
            r_klen <= key_len_in;
            r_key  <= key_in;
            r_kv   <= 1'b0;
         end
         if (r_state == S_LOAD) begin
            r_i   <= {2'b00, w_nk};
            r_pos <= 3'd0;
            r_rci <= 4'd1;
         end
         if (r_state == S_EXPAND) begin
            r_i <= r_i + 6'd1;
            if (r_pos == w_pos_last) begin
               r_pos <= 3'd0;
               // keep the Rcon index inside 1..10 after the final word
               if (!w_last) r_rci <= r_rci + 4'd1;
            end else begin
               r_pos <= r_pos + 3'd1;
            end
            if (w_last) r_kv <= 1'b1;
         end
      end
   end

   // ---------------- expansion datapath ----------------
   assign w_ix_m1  = r_i - 6'd1;
   assign w_ix_mnk = r_i - {2'b00, w_nk};
   assign w_im1    = r_w[w_ix_m1];
   assign w_imnk   = r_w[w_ix_mnk];
   assign w_rot    = {w_im1[23:0], w_im1[31:24]};
   assign w_sb_in  = (r_pos == 3'd0) ? w_rot : w_im1;

   for (genvar g = 0; g < 4; g++) begin : g_sbox
      sbox_combi u_sbox (
         .i_data     (w_sb_in[8*g +: 8]),
         .i_en_or_de (1'b1),
         .o_data     (w_sb_out[8*g +: 8])
      );
   end

   always_comb begin
      w_rcon = 8'h00;
      case (r_rci)
         4'd1:    w_rcon = 8'h01;
         4'd2:    w_rcon = 8'h02;
         4'd3:    w_rcon = 8'h04;
         4'd4:    w_rcon = 8'h08;
         4'd5:    w_rcon = 8'h10;
         4'd6:    w_rcon = 8'h20;
         4'd7:    w_rcon = 8'h40;
         4'd8:    w_rcon = 8'h80;
         4'd9:    w_rcon = 8'h1b;
         4'd10:   w_rcon = 8'h36;
         default: w_rcon = 8'h00;
      endcase
   end

   always_comb begin
      w_t = w_im1;
      if (r_pos == 3'd0)                         w_t = w_sb_out ^ {w_rcon, 24'h0};
      else if ((w_nk == 4'd8) && (r_pos == 3'd4)) w_t = w_sb_out;
   end

   assign w_new = w_imnk ^ w_t;

   // word table: not reset, validity tracked by r_kv
   always_ff @(posedge clk) begin
      if (r_state == S_LOAD) begin
         r_w[0] <= r_key[255:224];
         r_w[1] <= r_key[223:192];
         r_w[2] <= r_key[191:160];
         r_w[3] <= r_key[159:128];
         if (w_nk != 4'd4) begin
            r_w[4] <= r_key[127:96];
            r_w[5] <= r_key[95:64];
         end
         if (w_nk == 4'd8) begin
            r_w[6] <= r_key[63:32];
            r_w[7] <= r_key[31:0];
         end
      end else if (r_state == S_EXPAND) begin
         r_w[r_i] <= w_new;
      end
   end

   // ---------------- round-key read ----------------
   assign w_rbase = {rk_idx_in, 2'b00};

   always_comb begin
      w_rk = '0;
      if (rk_idx_in <= w_nr)
         w_rk = {r_w[w_rbase], r_w[w_rbase + 6'd1], r_w[w_rbase + 6'd2], r_w[w_rbase + 6'd3]};
   end

   if (RD_REG != 0) begin : g_rd_reg
      logic [127:0] r_rk;
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) r_rk <= '0;
         else          r_rk <= w_rk;
      end
      assign rk_out = r_rk;
   end else begin : g_rd_comb
      assign rk_out = w_rk;
   end

endmodule

// ---------------------------------------------------------------------------
// sbox_combi
//   Combinational AES S-box. Encrypt: affine(inv(x)); decrypt: inv(affine^-1(x)).
//   GF(2^8) inverse computed as x^254 with a fixed square/multiply chain.
// Ports
//   i_data      input byte
//   i_en_or_de  1 = forward S-box, 0 = inverse S-box
//   o_data      substituted byte
// ---------------------------------------------------------------------------
module sbox_combi (
   input  logic [7:0] i_data,
   input  logic       i_en_or_de,
   output logic [7:0] o_data
);

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] x2, x3, x12, x14, x15, x240;
      x2   = gmul(a, a);
      x3   = gmul(x2, a);
      x12  = gmul(gmul(x3, x3), gmul(x3, x3));
      x14  = gmul(x12, x2);
      x15  = gmul(x12, x3);
      x240 = gmul(x15, x15);
      x240 = gmul(x240, x240);
      x240 = gmul(x240, x240);
      x240 = gmul(x240, x240);
      return gmul(x240, x14);   // x^254 = x^-1, and 0 maps to 0
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
      return (a << n) | (a >> (8 - n));
   endfunction

   logic [7:0] w_fwd, w_inv;

   always_comb begin
      w_fwd  = ginv(i_data);
      w_fwd  = w_fwd ^ rotl(w_fwd, 1) ^ rotl(w_fwd, 2) ^ rotl(w_fwd, 3) ^ rotl(w_fwd, 4) ^ 8'h63;
      w_inv  = ginv(rotl(i_data, 1) ^ rotl(i_data, 3) ^ rotl(i_data, 6) ^ 8'h05);
      o_data = i_en_or_de ? w_fwd : w_inv;
   end

endmodule

// File: doc/aes_key_schedule_gen.md
AES_KEY_SCHEDULE_GEN -- requirements
Module: aes_key_schedule_gen

Interface
REQ-001 SHALL have parameter RD_REG, default 0, meaning 0 = combinational round-key read and 1 = registered read with one-cycle latency.
REQ-002 SHALL have parameter SUPPORT_256, default 1, meaning 0 = key_len 2'b10 is treated as invalid.
REQ-003 SHALL have port clk, input, 1, system clock, rising edge.
REQ-004 SHALL have port reset_n, input, 1, reset; reset_n is asynchronous, active-low; clock is clk.
REQ-005 SHALL have port start_in, input, 1, expansion request, sampled on the clk edge.
REQ-006 SHALL have port key_len_in, input, 2, key length: 00 = 128, 01 = 192, 10 = 256, 11 = invalid.
REQ-007 SHALL have port key_in, input, 256, cipher key; bits [255:224] are w[0], left-aligned; unused low bits are ignored.
REQ-008 SHALL have port rk_idx_in, input, 4, round-key index 0..14.
REQ-009 SHALL have port rk_out, output, 128, round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
REQ-010 SHALL have port busy_out, output, 1, high while expansion is in progress.
REQ-011 SHALL have port done_out, output, 1, one-cycle pulse when expansion completes.
REQ-012 SHALL have port keys_valid_out, output, 1, high when the word table holds a complete schedule.
REQ-013 SHALL have port err_out, output, 1, one-cycle pulse when start is rejected because key_len is invalid.

Function
REQ-014 SHALL derive Nk = 4/6/8 and Nr = 10/12/14 from key_len_in, latched at start acceptance; Nw = 4*(Nr+1) = 44/52/60.
REQ-015 SHALL implement FSM states IDLE, LOAD, EXPAND, DONE.
REQ-016 IDLE->LOAD SHALL occur when start_in=1 and key_len is valid; key_in and key_len are latched, and keys_valid_out is cleared at the same edge.
REQ-017 In IDLE, start_in=1 with an invalid key_len SHALL produce err_out high for the following cycle, remain in IDLE, and leave the table and keys_valid_out unchanged.
REQ-018 LOAD SHALL write w[0..Nk-1] from the latched key in one cycle, set i=Nk, and go to EXPAND.
REQ-019 EXPAND SHALL compute one word per cycle: w[i] = w[i-Nk] ^ t.
REQ-020 In EXPAND, t SHALL be:
- SubWord(RotWord(w[i-1])) ^ {Rcon[i/Nk], 24'h0} when i mod Nk = 0;
- SubWord(w[i-1]) when Nk=8 and i mod Nk = 4;
- w[i-1] otherwise.
REQ-021 RotWord SHALL be {b1,b2,b3,b0}; Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36.
REQ-022 SubWord SHALL use exactly 4 instances of the team sbox_combi in encrypt mode (en_or_de=1); no more S-box instances are permitted.
REQ-023 i SHALL increment per EXPAND cycle; EXPAND->DONE SHALL occur at the edge that writes w[Nw-1].
REQ-024 DONE SHALL assert done_out and keys_valid_out for that cycle, then go to IDLE; keys_valid_out stays high until the next accepted start or reset.
REQ-025 Latency from start sample edge to done_out high SHALL be Nw-Nk+2 cycles: 42 (AES-128), 48 (AES-192), 54 (AES-256).
REQ-026 busy_out SHALL be high in LOAD, EXPAND and DONE, and low in IDLE.
REQ-027 start_in SHALL be ignored when not in IDLE, and no err_out SHALL be produced.
REQ-028 rk_out SHALL be read from the word table at any time, including during expansion; contents are only guaranteed when keys_valid_out=1.
REQ-029 rk_out SHALL be 128'h0 when rk_idx_in > Nr (latched Nr).
REQ-030 With RD_REG=1, rk_out SHALL reflect rk_idx_in from the previous edge.
REQ-031 Index arithmetic SHALL use 6-bit i with no wrap-around past 59; Rcon index i/Nk never exceeds 10 (128), 8 (192) or 7 (256).

Reset
REQ-032 reset_n low SHALL force IDLE and clear busy_out, done_out, err_out, keys_valid_out, i, and the latched key_len.
REQ-033 With RD_REG=1, reset_n low SHALL also clear the rk_out register.
REQ-034 The word table need not be cleared on reset; rk_out content is don't-care while keys_valid_out=0.
REQ-035 Reset mid-expansion SHALL abort the expansion; keys_valid_out remains 0 until a new expansion completes.

Verification
REQ-036 AES-128 scenario: key 2b7e151628aed2a6abf7158809cf4f3c -> done_out after 42 cycles, and rk_idx=10 returns d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-037 AES-192 scenario: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done_out after 48 cycles, and rk_idx=12 returns e98ba06f448c773c8ecc720401002202.
REQ-038 AES-256 scenario: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d98 10a30914dff4 -> done_out after 54 cycles, and rk_idx=14 returns fe4890d1e6188d0b046df344706c631e.
REQ-039 Invalid-length scenario: key_len=11 with start -> err_out pulses once, busy_out stays 0, and keys_valid_out is unchanged.
REQ-040 Out-of-range scenario: AES-128 completed, then rk_idx=11..14 -> rk_out = 0.
REQ-041 Abort scenario: start AES-256, assert reset_n low at cycle 20 -> all outputs 0; a restarted AES-128 expansion then matches REQ-036.
